mc_cpu_core: RTL and testbench

//  Parametrised multi-cycle successor of the 16-bit single-cycle CPU. Same 16-bit ISA (type/dest/src1/src2/func),

---
 rtl/mc_cpu_pkg.sv | 46 ++++
 rtl/mc_cpu_alu.sv | 47 ++++
 rtl/mc_cpu_core.sv | 165 ++++++++++++++++
 tb/tb_mc_cpu_core.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_cpu_pkg.sv
// Shared definitions for the multi-cycle 16-bit-ISA core: instruction types,
// function codes, instruction field positions and the sequencing FSM states.
// The HALT state exists only when MC_CPU_HALT_EN is defined.
package mc_cpu_pkg;

  localparam logic [1:0] T_ALU = 2'b00;
  localparam logic [1:0] T_LDI = 2'b01;
  localparam logic [1:0] T_JMP = 2'b10;
  localparam logic [1:0] T_BR  = 2'b11;

  localparam logic [1:0] F_ADD = 2'b00;
  localparam logic [1:0] F_SUB = 2'b01;
  localparam logic [1:0] F_AND = 2'b10;
  localparam logic [1:0] F_OR  = 2'b11;

  localparam logic [1:0] F_BEQ = 2'b00;
  localparam logic [1:0] F_BNE = 2'b01;
  localparam logic [1:0] F_NOP = 2'b10;
  localparam logic [1:0] F_HLT = 2'b11;

  // Instruction word layout: type[15:14] dest[13:10] src1[9:6] src2[5:2] func[1:0]
  localparam int TYPE_HI = 15;
  localparam int TYPE_LO = 14;
  localparam int DEST_HI = 13;
  localparam int DEST_LO = 10;
  localparam int SRC1_HI = 9;
  localparam int SRC1_LO = 6;
  localparam int SRC2_HI = 5;
  localparam int SRC2_LO = 2;
  localparam int FUNC_HI = 1;
  localparam int FUNC_LO = 0;
  localparam int IMM_HI  = 9;
  localparam int JMP_HI  = 13;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3
`ifdef MC_CPU_HALT_EN
    ,
    S_HALT   = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/mc_cpu_alu.sv
// Combinational ALU: ADD/SUB/AND/OR with zero, carry (borrow on SUB) and
// signed overflow flags.
module mc_cpu_alu
  import mc_cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [1:0]        func,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              carry,
  output logic              overflow
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Select the operation; the extra top bit of sum/diff is carry-out/borrow
  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (func)
      F_ADD: begin
        result   = sum[MSB:0];
        carry    = sum[DATA_W];
        overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
      end
      F_SUB: begin
        result   = diff[MSB:0];
        carry    = diff[DATA_W];
        overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
      end
      F_AND:   result = a & b;
      default: result = a | b;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/mc_cpu_core.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC/WB sequencing over a req/ack
// instruction port, owning PC, IR, 16-entry register file and ALU flags.
// Optional feature macro: MC_CPU_HALT_EN (type 11 func 11 halts the core;
// otherwise it behaves as a NOP and halted is tied low).
module mc_cpu_core
  import mc_cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_ack,
  output logic              retire,
  output logic [ADDR_W-1:0] retire_pc,
  output logic              zero,
  output logic              carry,
  output logic              overflow,
  output logic              halted
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       ir;
  logic [DATA_W-1:0] rf [16];
  logic [DATA_W-1:0] a_p1;
  logic [DATA_W-1:0] b_p1;
  logic [DATA_W-1:0] res_p2;

  logic [1:0]        typ;
  logic [3:0]        dest;
  logic [3:0]        src1;
  logic [3:0]        src2;
  logic [1:0]        func;
  logic [DATA_W-1:0] imm;
  logic [ADDR_W-1:0] pc_next;

  logic [DATA_W-1:0] alu_res;
  logic              alu_z;
  logic              alu_c;
  logic              alu_v;

  assign typ  = ir[TYPE_HI:TYPE_LO];
  assign dest = ir[DEST_HI:DEST_LO];
  assign src1 = ir[SRC1_HI:SRC1_LO];
  assign src2 = ir[SRC2_HI:SRC2_LO];
  assign func = ir[FUNC_HI:FUNC_LO];
  assign imm  = DATA_W'(ir[IMM_HI:0]);

  assign imem_addr = pc;

  mc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a        (a_p1),
    .b        (b_p1),
    .func     (func),
    .result   (alu_res),
    .zero     (alu_z),
    .carry    (alu_c),
    .overflow (alu_v)
  );

  // Next PC: jump target, taken branch to {0,dest}, else wrap-around increment
  always_comb begin
    pc_next = pc + ADDR_W'(1);
    case (typ)
      T_JMP: pc_next = ADDR_W'(ir[JMP_HI:0]);
      T_BR: begin
        if ((func == F_BEQ && a_p1 == b_p1) || (func == F_BNE && a_p1 != b_p1))
          pc_next = ADDR_W'(dest);
      end
      default: ;
    endcase
  end

`ifdef MC_CPU_HALT_EN
  logic halted_r;
  assign halted = halted_r;
`else
  assign halted = 1'b0;
`endif

  // Instruction sequencer with registered outputs and architectural state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_FETCH;
      pc        <= '0;
      ir        <= '0;
      a_p1      <= '0;
      b_p1      <= '0;
      res_p2    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
      overflow  <= 1'b0;
      imem_req  <= 1'b0;
      retire    <= 1'b0;
      retire_pc <= '0;
`ifdef MC_CPU_HALT_EN
      halted_r  <= 1'b0;
`endif
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      retire <= 1'b0;
      case (state)
        // Fetch: raise req if not already up, capture the word on ack
        S_FETCH: begin
          if (!imem_req) begin
            imem_req <= 1'b1;
          end else if (imem_ack) begin
            ir       <= imem_rdata;
            imem_req <= 1'b0;
            state    <= S_DECODE;
          end
        end
        // Decode: latch operands so dest may alias a source
        S_DECODE: begin
          a_p1  <= rf[src1];
          b_p1  <= rf[src2];
          state <= S_EXEC;
        end
        // Execute: register ALU result; only ALU-type updates flags
        S_EXEC: begin
          res_p2 <= alu_res;
          if (typ == T_ALU) begin
            zero     <= alu_z;
            carry    <= alu_c;
            overflow <= alu_v;
          end
          retire    <= 1'b1;
          retire_pc <= pc;
          state     <= S_WB;
        end
        // Write back: register write, PC update, start next fetch
        S_WB: begin
          case (typ)
            T_ALU:   rf[dest] <= res_p2;
            T_LDI:   rf[dest] <= imm;
            default: ;
          endcase
          pc <= pc_next;
`ifdef MC_CPU_HALT_EN
          if (typ == T_BR && func == F_HLT) begin
            halted_r <= 1'b1;
            state    <= S_HALT;
          end else begin
            imem_req <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
`else
          imem_req <= 1'b1;
          state    <= S_FETCH;
        end
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_cpu_core.sv
// Directed testbench for mc_cpu_core (DATA_W=8, ADDR_W=8) with an instruction
// memory responder that inserts a programmable number of wait states per fetch.
// Halt expectations follow MC_CPU_HALT_EN when the bench is built with it.
module tb_mc_cpu_core;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_rdata;
  logic          imem_ack;
  logic          retire;
  logic [AW-1:0] retire_pc;
  logic          zero, carry, overflow, halted;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0]   mem [256];
  int            wpat [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
  int            wpat_len = 1;
  int            fetch_no = 0;
  int            wcnt = 0;
  int            stab_err = 0;
  logic          in_fetch = 1'b0;
  logic [AW-1:0] held_addr = '0;
  int            cyc = 0;
  logic [AW-1:0] fetchq [$];
  logic [AW-1:0] retq [$];
  int            retcyc [$];

  mc_cpu_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .retire     (retire),
    .retire_pc  (retire_pc),
    .zero       (zero),
    .carry      (carry),
    .overflow   (overflow),
    .halted     (halted)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Instruction memory: answers on the falling edge after the programmed waits
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (reset) begin
        imem_ack = 1'b0;
        wcnt     = 0;
        in_fetch = 1'b0;
      end else if (imem_req) begin
        if (in_fetch && imem_addr !== held_addr) stab_err++;
        in_fetch  = 1'b1;
        held_addr = imem_addr;
        if (wcnt >= wpat[fetch_no % wpat_len]) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr];
          fetchq.push_back(imem_addr);
          fetch_no++;
          wcnt     = 0;
          in_fetch = 1'b0;
        end else begin
          imem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        imem_ack = 1'b0;
      end
    end
  end

  task automatic fill_nop();
    for (int i = 0; i < 256; i++) mem[i] = 16'hC002;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fetchq.delete();
    retq.delete();
    retcyc.delete();
    fetch_no = 0;
    stab_err = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_retires(input int n, input int budget);
    int k = 0;
    while (retq.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      if (retire) begin
        retq.push_back(retire_pc);
        retcyc.push_back(cyc);
      end
      k++;
    end
    n_cmp++;
    if (retq.size() < n) begin
      n_bad++;
      $display("FAIL retire_timeout: got %0d retires, required %0d", retq.size(), n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b, required 0", imem_req); end
    n_cmp++; if ({zero, carry, overflow} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b, required 000", {zero, carry, overflow}); end
    n_cmp++; if ({retire, halted} !== 2'b00) begin n_bad++; $display("FAIL reset_retire_halted: got %b, required 00", {retire, halted}); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin n_bad++; $display("FAIL reset_first_fetch: got req=%b addr=%h, required req=1 addr=00", imem_req, imem_addr); end
  endtask

  // LDI R1,200; LDI R2,100; ADD R3,R1,R2 -> 44 with carry
  task automatic test_alu();
    fill_nop();
    mem[0] = 16'h44C8;
    mem[1] = 16'h4864;
    mem[2] = 16'h0C48;
    do_reset();
    run_retires(3, 60);
    n_cmp++; if (retq[0] !== 8'd0 || retq[1] !== 8'd1 || retq[2] !== 8'd2) begin n_bad++; $display("FAIL alu_retire_pcs: got %0d,%0d,%0d, required 0,1,2", retq[0], retq[1], retq[2]); end
    n_cmp++; if ({zero, carry, overflow} !== 3'b010) begin n_bad++; $display("FAIL alu_add_flags: got zco=%b, required 010", {zero, carry, overflow}); end
  endtask

  // SUB then BEQ to 9: taken when equal, falls through to 4 otherwise
  task automatic test_branch();
    logic [15:0]   ldi_r2 [2] = '{16'h4805, 16'h4804};
    logic          exp_z  [2] = '{1'b1, 1'b0};
    logic [AW-1:0] exp_pc [2] = '{8'd9, 8'd4};
    for (int c = 0; c < 2; c++) begin
      fill_nop();
      mem[0] = 16'h4405;
      mem[1] = ldi_r2[c];
      mem[2] = 16'h0C49;
      mem[3] = 16'hE448;
      do_reset();
      run_retires(4, 80);
      n_cmp++; if (zero !== exp_z[c]) begin n_bad++; $display("FAIL branch_zero[%0d]: got %b, required %b", c, zero, exp_z[c]); end
      n_cmp++; if (retq[3] !== 8'd3) begin n_bad++; $display("FAIL branch_retire_pc[%0d]: got %0d, required 3", c, retq[3]); end
      @(posedge clk);
      #1;
      n_cmp++; if (imem_addr !== exp_pc[c] || imem_req !== 1'b1) begin n_bad++; $display("FAIL branch_next_addr[%0d]: got addr=%0d req=%b, required addr=%0d req=1", c, imem_addr, imem_req, exp_pc[c]); end
    end
  endtask

  // Waits 0,1,7 repeating: retire spacing 4+wait of the next fetch
  task automatic test_waits();
    fill_nop();
    wpat[0] = 0; wpat[1] = 1; wpat[2] = 7;
    wpat_len = 3;
    do_reset();
    run_retires(4, 200);
    n_cmp++; if (retcyc[1] - retcyc[0] !== 5) begin n_bad++; $display("FAIL wait_spacing1: got %0d, required 5", retcyc[1] - retcyc[0]); end
    n_cmp++; if (retcyc[2] - retcyc[1] !== 11) begin n_bad++; $display("FAIL wait_spacing2: got %0d, required 11", retcyc[2] - retcyc[1]); end
    n_cmp++; if (retcyc[3] - retcyc[2] !== 4) begin n_bad++; $display("FAIL wait_spacing3: got %0d, required 4", retcyc[3] - retcyc[2]); end
    n_cmp++; if (stab_err !== 0) begin n_bad++; $display("FAIL wait_addr_stable: got %0d changes, required 0", stab_err); end
    n_cmp++; if (retq[3] !== 8'd3) begin n_bad++; $display("FAIL wait_retire_pc: got %0d, required 3", retq[3]); end
    wpat[0] = 0; wpat[1] = 0; wpat[2] = 0;
    wpat_len = 1;
  endtask

  // JUMP 14'h3FFF truncates to FF; PC FF + 1 wraps to 0
  task automatic test_wrap();
    fill_nop();
    mem[0] = 16'hBFFF;
    do_reset();
    run_retires(2, 60);
    n_cmp++; if (fetchq[1] !== 8'hFF) begin n_bad++; $display("FAIL wrap_jump_trunc: got %h, required ff", fetchq[1]); end
    n_cmp++; if (retq[1] !== 8'hFF) begin n_bad++; $display("FAIL wrap_retire_pc: got %h, required ff", retq[1]); end
    @(posedge clk);
    #1;
    n_cmp++; if (imem_addr !== 8'h00 || imem_req !== 1'b1) begin n_bad++; $display("FAIL wrap_next_addr: got addr=%h req=%b, required addr=00 req=1", imem_addr, imem_req); end
  endtask

  // Reset during a waited fetch: req drops at once, state cleared
  task automatic test_reset_mid();
    fill_nop();
    mem[0] = 16'h44C8;
    mem[1] = 16'h4864;
    mem[2] = 16'h0C48;
    wpat[0] = 0; wpat[1] = 0; wpat[2] = 0; wpat[3] = 7;
    wpat_len = 4;
    do_reset();
    run_retires(3, 60);
    n_cmp++; if (carry !== 1'b1) begin n_bad++; $display("FAIL mid_pre_carry: got %b, required 1", carry); end
    repeat (3) @(posedge clk);
    #2;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 8'd3) begin n_bad++; $display("FAIL mid_pre_req: got req=%b addr=%0d, required req=1 addr=3", imem_req, imem_addr); end
    reset = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL mid_req_drop: got %b, required 0", imem_req); end
    n_cmp++; if ({zero, carry, overflow} !== 3'b000 || imem_addr !== 8'h00) begin n_bad++; $display("FAIL mid_state_clear: got flags=%b addr=%h, required flags=000 addr=00", {zero, carry, overflow}, imem_addr); end
    mem[0] = 16'hD448;
    wpat[3] = 0;
    wpat_len = 1;
    fetchq.delete();
    retq.delete();
    retcyc.delete();
    fetch_no = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_retires(1, 40);
    n_cmp++; if (fetchq[0] !== 8'h00) begin n_bad++; $display("FAIL mid_refetch_addr: got %h, required 00", fetchq[0]); end
    @(posedge clk);
    #1;
    n_cmp++; if (imem_addr !== 8'd5) begin n_bad++; $display("FAIL mid_regs_cleared: got next addr %0d, required 5", imem_addr); end
  endtask

  // 16'hFFFF at address 3: halts with the macro, NOP without
  task automatic test_halt();
    int reqs = 0;
    fill_nop();
    mem[3] = 16'hFFFF;
    do_reset();
    run_retires(4, 80);
    n_cmp++; if (retq[3] !== 8'd3) begin n_bad++; $display("FAIL halt_retire_pc: got %0d, required 3", retq[3]); end
    @(posedge clk);
    #1;
`ifdef MC_CPU_HALT_EN
    n_cmp++; if (halted !== 1'b1 || imem_req !== 1'b0) begin n_bad++; $display("FAIL halt_enter: got halted=%b req=%b, required halted=1 req=0", halted, imem_req); end
    repeat (100) begin
      @(posedge clk);
      #1;
      if (imem_req) reqs++;
    end
    n_cmp++; if (reqs !== 0) begin n_bad++; $display("FAIL halt_no_fetch: got %0d req cycles, required 0", reqs); end
    n_cmp++; if (imem_addr !== 8'd4 || halted !== 1'b1) begin n_bad++; $display("FAIL halt_pc: got addr=%0d halted=%b, required addr=4 halted=1", imem_addr, halted); end
`else
    n_cmp++; if (imem_addr !== 8'd4 || imem_req !== 1'b1) begin n_bad++; $display("FAIL nohalt_next: got addr=%0d req=%b, required addr=4 req=1", imem_addr, imem_req); end
    repeat (20) begin
      @(posedge clk);
      #1;
      if (halted) reqs++;
    end
    n_cmp++; if (reqs !== 0) begin n_bad++; $display("FAIL nohalt_halted: got %0d halted cycles, required 0", reqs); end
`endif
  endtask

  initial begin
    fill_nop();
    test_reset();
    test_alu();
    test_branch();
    test_waits();
    test_wrap();
    test_reset_mid();
    test_halt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
